// File: rtl/rc4_cipher_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rc4_cipher_ctrl
//  Purpose  : RC4 session controller. Collects the key, sequences the PRGA
//             core's reset / password feed, buffers the free-running
//             keystream in a small FIFO and XORs it onto the byte stream.
//  Revision : 1.0  initial release
// ============================================================================
module rc4_cipher_ctrl #(
    parameter int KEY_SIZE   = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int DISCARD    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] key_byte,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       core_rst,
    output logic [7:0] core_key,
    input  logic       core_ready,
    input  logic [7:0] core_k,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       overrun
);

    localparam int            IW       = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(KEY_SIZE - 1);
    localparam logic [7:0]    DISC_MAX = 8'(DISCARD);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CRST = 3'd2;
    localparam logic [2:0] S_FEED = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [7:0]    key_q [KEY_SIZE];
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic [7:0]    dcnt_q;
    logic          overrun_q;

    logic          w_run;
    logic          w_empty;
    logic          w_full;
    logic          w_cap;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_ovf;

    // FIFO status: pointers carry one extra wrap bit so full and empty differ
    assign w_empty   = (wr_q == rd_q);
    assign w_full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign w_run     = (state_q == S_RUN);

    // Keystream capture: the core never stalls, so every valid byte in RUN
    // is either discarded, stored, or lost (overrun)
    assign w_cap     = w_run && core_ready && !start;
    assign w_drop    = (dcnt_q != DISC_MAX);
    assign w_push    = w_cap && !w_drop;
    assign w_pop     = din_valid && din_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_ovf     = w_push && w_full && !w_pop;

    // Zero-latency data path; a transfer consumes exactly one keystream byte
    assign din_ready  = dout_ready && !w_empty && w_run;
    assign dout_valid = din_valid && !w_empty && w_run;
    assign dout       = din ^ mem_q[rd_q[AW-1:0]];
    assign overrun    = overrun_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start overrides everything and reopens key collection
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_LOAD: if (key_valid && (idx_q == IDX_LAST)) state_d = S_CRST;
                S_CRST: state_d = S_FEED;
                S_FEED: if (idx_q == IDX_LAST) state_d = S_RUN;
                S_RUN:  if (w_ovf) state_d = S_ERR;
                S_ERR:  state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs; the core is held in reset except while keyed or running
    always_comb begin
        core_rst  = 1'b1;
        core_key  = key_q[0];
        key_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_LOAD: begin
                key_ready = 1'b1;
                busy      = 1'b1;
            end
            S_CRST: busy = 1'b1;
            S_FEED: begin
                core_rst = 1'b0;
                busy     = 1'b1;
                for (int i = 0; i < KEY_SIZE; i++) begin
                    if (idx_q == IW'(i)) core_key = key_q[i];
                end
            end
            S_RUN: begin
                core_rst = 1'b0;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // Key byte capture in LOAD and key index sequencing through FEED
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            for (int i = 0; i < KEY_SIZE; i++) key_q[i] <= 8'h00;
        end else if (start) begin
            idx_q <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (key_valid) begin
                        for (int i = 0; i < KEY_SIZE; i++) begin
                            if (idx_q == IW'(i)) key_q[i] <= key_byte;
                        end
                        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end
                end
                S_FEED:  idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                default: idx_q <= '0;
            endcase
        end
    end

    // FIFO pointers, discard counter and sticky overrun flag; start flushes all
    always_ff @(posedge clk) begin
        if (rst || start) begin
            wr_q      <= '0;
            rd_q      <= '0;
            dcnt_q    <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            if (w_push_ok)       wr_q      <= wr_q + 1'b1;
            if (w_pop)           rd_q      <= rd_q + 1'b1;
            if (w_cap && w_drop) dcnt_q    <= dcnt_q + 8'h01;
            if (w_ovf)           overrun_q <= 1'b1;
        end
    end

    // Keystream storage
    always_ff @(posedge clk) begin
        if (w_push_ok) mem_q[wr_q[AW-1:0]] <= core_k;
    end

endmodule
`default_nettype wire

// File: tb/tb_rc4_cipher_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rc4_cipher_ctrl
//  Purpose  : Directed bench for rc4_cipher_ctrl with a behavioural RC4 core
//             model; a second instance with DISCARD=2 shares the core model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rc4_cipher_ctrl;

    localparam int KS = 6;

    typedef logic [7:0] ks_t [64];

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] key_byte;
    logic       key_valid;
    logic [7:0] din;
    logic       din_valid;
    logic       dout_ready;
    logic       core_ready;
    logic [7:0] core_k;

    logic       key_ready, core_rst, din_ready, dout_valid, busy, overrun;
    logic [7:0] core_key, dout;

    logic       d1_key_ready, d1_core_rst, d1_din_ready, d1_dout_valid, d1_busy, d1_overrun;
    logic [7:0] d1_core_key, d1_dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] d1q[$];

    logic [8*KS-1:0] secret = {8'h74, 8'h65, 8'h72, 8'h63, 8'h65, 8'h53};
    logic [7:0]      ks_exp [8] = '{8'h04, 8'hd4, 8'h6b, 8'h05, 8'h3c, 8'ha8, 8'h7b, 8'h59};

    always #5 clk = ~clk;

    rc4_cipher_ctrl #(.KEY_SIZE(KS), .FIFO_DEPTH(4), .DISCARD(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .key_byte(key_byte), .key_valid(key_valid), .key_ready(key_ready),
        .core_rst(core_rst), .core_key(core_key), .core_ready(core_ready), .core_k(core_k),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .overrun(overrun)
    );

    rc4_cipher_ctrl #(.KEY_SIZE(KS), .FIFO_DEPTH(4), .DISCARD(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .key_byte(key_byte), .key_valid(key_valid), .key_ready(d1_key_ready),
        .core_rst(d1_core_rst), .core_key(d1_core_key), .core_ready(core_ready), .core_k(core_k),
        .din(8'h00), .din_valid(1'b1), .din_ready(d1_din_ready),
        .dout(d1_dout), .dout_valid(d1_dout_valid), .dout_ready(1'b1),
        .busy(d1_busy), .overrun(d1_overrun)
    );

    // Reference RC4: KSA over the fed key, then the first 64 PRGA bytes
    function automatic ks_t rc4_gen(input logic [8*KS-1:0] k);
        logic [7:0] s [256];
        logic [7:0] t;
        ks_t        r;
        int         i, j;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + int'(s[n]) + int'(k[8*(n%KS) +: 8])) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int n = 0; n < 64; n++) begin
            i = (i + 1) % 256;
            j = (j + int'(s[i])) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            r[n] = s[(int'(s[i]) + int'(s[j])) % 256];
        end
        return r;
    endfunction

    // Core model: takes KS key bytes after reset release, then emits one
    // keystream byte every other cycle without ever stalling
    logic [8*KS-1:0] ckey;
    int              ccnt;
    int              gi;
    logic            tog;
    ks_t             kstream;
    always @(posedge clk) begin
        if (core_rst) begin
            ccnt       <= 0;
            gi         <= 0;
            tog        <= 1'b0;
            core_ready <= 1'b0;
            core_k     <= 8'h00;
        end else if (ccnt < KS) begin
            ckey[8*ccnt +: 8] <= core_key;
            ccnt              <= ccnt + 1;
            core_ready        <= 1'b0;
        end else if (ccnt == KS) begin
            kstream <= rc4_gen(ckey);
            ccnt    <= KS + 1;
        end else begin
            tog <= ~tog;
            if (tog && gi < 64) begin
                core_ready <= 1'b1;
                core_k     <= kstream[gi];
                gi         <= gi + 1;
            end else begin
                core_ready <= 1'b0;
            end
        end
    end

    // Record the DISCARD=2 instance's output stream
    always @(negedge clk) begin
        if (d1_dout_valid) d1q.push_back(d1_dout);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d1q.delete();
    endtask

    task automatic send_key(input int nbytes, input logic [8*KS-1:0] k);
        int cyc;
        for (int i = 0; i < nbytes; i++) begin
            key_byte  = k[8*i +: 8];
            key_valid = 1'b1;
            cyc = 0;
            while (!key_ready && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (!key_ready) check("key_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
    endtask

    // Push one byte through the data path and compare the XOR result
    task automatic xfer(input string tag, input logic [7:0] d, input logic [7:0] exp);
        int cyc;
        logic got;
        din        = d;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 100) begin
            @(negedge clk); #1;
            if (dout_valid) got = 1'b1;
            cyc++;
        end
        if (got) check(tag, {24'h0, dout}, {24'h0, exp});
        else     check({tag, "_timeout"}, 0, 1);
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        key_byte   = 8'h00;
        key_valid  = 1'b0;
        din        = 8'h00;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_rst",  {31'h0, core_rst},  1);
        check("rst_core_key",  {24'h0, core_key},  0);
        check("rst_key_ready", {31'h0, key_ready}, 0);
        check("rst_outs", {28'h0, din_ready, dout_valid, busy, overrun}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: "Secret", plaintext zeros gives the raw keystream
        pulse_start();
        check("load_key_ready", {31'h0, key_ready}, 1);
        check("load_busy",      {31'h0, busy},      1);
        send_key(KS, secret);
        for (int i = 0; i < 8; i++) xfer($sformatf("t1_ks%0d", i), 8'h00, ks_exp[i]);

        // 2: DISCARD=2 instance starts two bytes later in the stream
        check("t2_count", {31'h0, d1q.size() >= 4}, 1);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_drop%0d", i), (i < d1q.size()) ? {24'h0, d1q[i]} : 32'hdead,
                  {24'h0, ks_exp[i+2]});

        // 3: round trip of the ciphertext, then 'A' -> 0x45
        pulse_start();
        send_key(KS, secret);
        for (int i = 0; i < 8; i++) xfer($sformatf("t3_rt%0d", i), ks_exp[i], 8'h00);
        pulse_start();
        send_key(KS, secret);
        xfer("t3_enc_A", 8'h41, 8'h45);

        // 4: sink stalled in RUN until the keystream overflows the buffer
        pulse_start();
        send_key(KS, secret);
        din        = 8'h00;
        din_valid  = 1'b1;
        dout_ready = 1'b0;
        for (int i = 0; i < 60 && !overrun; i++) begin
            @(posedge clk); #1;
        end
        check("t4_overrun",  {31'h0, overrun},   1);
        check("t4_busy",     {31'h0, busy},      0);
        check("t4_core_rst", {31'h0, core_rst},  1);
        check("t4_din_rdy",  {31'h0, din_ready}, 0);
        din_valid = 1'b0;
        pulse_start();
        check("t4_ovr_clr", {31'h0, overrun}, 0);
        send_key(KS, secret);
        xfer("t4_restart0", 8'h00, 8'h04);
        xfer("t4_restart1", 8'h00, 8'hd4);

        // 5: start mid-load with a coincident key byte that must be ignored
        pulse_start();
        send_key(3, secret);
        key_byte  = 8'hff;
        key_valid = 1'b1;
        pulse_start();
        key_valid = 1'b0;
        check("t5_key_ready", {31'h0, key_ready}, 1);
        send_key(KS, secret);
        xfer("t5_ks0", 8'h00, 8'h04);
        xfer("t5_ks1", 8'h00, 8'hd4);

        // 6: reset mid-session returns all outputs to idle values
        xfer("t6_ks2", 8'h00, 8'h6b);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_core_rst", {31'h0, core_rst}, 1);
        check("t6_core_key", {24'h0, core_key}, 0);
        check("t6_outs", {27'h0, key_ready, din_ready, dout_valid, busy, overrun}, 0);
        key_byte  = 8'h55;
        key_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("t6_idle_key_ready", {31'h0, key_ready}, 0);
        check("t6_idle_busy",      {31'h0, busy},      0);
        check("t6_idle_core_key",  {24'h0, core_key},  0);
        pulse_start();
        send_key(KS, secret);
        xfer("t6_after0", 8'h00, 8'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
